// File: rtl/mux_sel_ctrl_pkg.sv
// Shared types for the 2:1 mux select controller: FSM states, owner encoding
// and the hold-counter width helper.
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    GAP   = 2'd3
  } sel_state_e;

  // Encoding matches o_sel polarity: 1 routes A, 0 routes B.
  typedef enum logic {
    OWN_SRC_B = 1'b0,
    OWN_SRC_A = 1'b1
  } owner_e;

  function automatic int cnt_width(input int min_hold, input int max_hold);
    int m;
    m = (max_hold > min_hold) ? max_hold : min_hold;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mux_sel_ctrl.sv
// Round-robin select controller for a downstream 2:1 mux with min/max hold
// time and a one-cycle dead gap on every ownership change.
module mux_sel_ctrl
  import mux_sel_pkg::*;
#(
  parameter int MIN_HOLD = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_sel,
  output logic o_gnt_a,
  output logic o_gnt_b,
  output logic o_gap
);

  localparam int                CNT_W   = cnt_width(MIN_HOLD, MAX_HOLD);
  localparam logic [CNT_W-1:0]  MIN_LIM = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0]  MAX_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT = '1;
  localparam bit                PREEMPT = (MAX_HOLD != 0);

  if (MIN_HOLD < 1) begin : g_bad_min_hold
    $error("mux_sel_ctrl: MIN_HOLD must be >= 1");
  end
  if (MAX_HOLD < 0 || (MAX_HOLD != 0 && MAX_HOLD < MIN_HOLD)) begin : g_bad_max_hold
    $error("mux_sel_ctrl: MAX_HOLD must be 0 or >= MIN_HOLD");
  end

  sel_state_e       state;
  sel_state_e       state_nxt;
  owner_e           last;
  logic [CNT_W-1:0] cnt;
  logic             hold_done;
  logic             preempt_due;

  // Ties go to whichever source did not own the mux most recently.
  function automatic sel_state_e arbitrate(input logic a, input logic b, input owner_e lst);
    if (a && b)  return (lst == OWN_SRC_B) ? OWN_A : OWN_B;
    else if (a)  return OWN_A;
    else if (b)  return OWN_B;
    else         return IDLE;
  endfunction

  always_comb begin
    state_nxt   = state;
    hold_done   = (cnt >= MIN_LIM);
    preempt_due = PREEMPT && (cnt >= MAX_LIM);
    case (state)
      IDLE, GAP: state_nxt = arbitrate(i_req_a, i_req_b, last);
      OWN_A: begin
        if ((!i_req_a && hold_done) || (preempt_due && i_req_b)) state_nxt = GAP;
      end
      OWN_B: begin
        if ((!i_req_b && hold_done) || (preempt_due && i_req_a)) state_nxt = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they always equal
  // a decode of the registered state and never see a combinational input path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      last    <= OWN_SRC_B;
      cnt     <= '0;
      o_sel   <= 1'b0;
      o_gnt_a <= 1'b0;
      o_gnt_b <= 1'b0;
      o_gap   <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_gnt_a <= (state_nxt == OWN_A);
      o_gnt_b <= (state_nxt == OWN_B);
      o_gap   <= (state_nxt == GAP);

      if (state_nxt == OWN_A && state != OWN_A) begin
        o_sel <= OWN_SRC_A;
        cnt   <= '0;
      end else if (state_nxt == OWN_B && state != OWN_B) begin
        o_sel <= OWN_SRC_B;
        cnt   <= '0;
      end else if ((state == OWN_A || state == OWN_B) && cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end

      if (state_nxt == GAP && state != GAP)
        last <= (state == OWN_A) ? OWN_SRC_A : OWN_SRC_B;
    end
  end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed scoreboard bench for mux_sel_ctrl plus a random run checking the
// grant exclusivity and select-stability invariants.
module tb_mux_sel_ctrl;

  logic clk;
  logic rst_n, req_a, req_b;
  logic sel, gnt_a, gnt_b, gap;
  logic rst2_n, req_a2, req_b2;
  logic sel2, gnt_a2, gnt_b2, gap2;

  int checks = 0;
  int errors = 0;
  int dut_pick = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  logic p_sel = 1'b0;
  logic p_ga  = 1'b0;
  logic p_gb  = 1'b0;
  logic p_rst = 1'b0;

  mux_sel_ctrl #(.MIN_HOLD(4), .MAX_HOLD(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_a(req_a), .i_req_b(req_b),
    .o_sel(sel), .o_gnt_a(gnt_a), .o_gnt_b(gnt_b), .o_gap(gap)
  );

  mux_sel_ctrl #(.MIN_HOLD(4), .MAX_HOLD(0)) u_dut_nolim (
    .i_clk(clk), .i_rst_n(rst2_n), .i_req_a(req_a2), .i_req_b(req_b2),
    .o_sel(sel2), .o_gnt_a(gnt_a2), .o_gnt_b(gnt_b2), .o_gap(gap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vectors are {sel, gnt_a, gnt_b, gap}.
  task automatic push(input logic [3:0] e, input int n, input string tag);
    repeat (n) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  task automatic inv_check();
    checks++;
    assert (!(gnt_a && gnt_b)) else begin
      errors++;
      $error("FAIL grant_excl observed gnt_a=%b gnt_b=%b expected not both 1", gnt_a, gnt_b);
    end
    if (rst_n && p_rst && (sel !== p_sel)) begin
      checks++;
      assert ((gnt_a && !p_ga) || (gnt_b && !p_gb)) else begin
        errors++;
        $error("FAIL sel_stable observed sel %b->%b with gnt_a=%b gnt_b=%b expected change only on grant rise",
               p_sel, sel, gnt_a, gnt_b);
      end
    end
    p_sel = sel;
    p_ga  = gnt_a;
    p_gb  = gnt_b;
    p_rst = rst_n;
  endtask

  task automatic compare_now();
    logic [3:0] obs;
    logic [3:0] exp;
    string      t;
    obs = (dut_pick != 0) ? {sel2, gnt_a2, gnt_b2, gap2} : {sel, gnt_a, gnt_b, gap};
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b expected=<queued vector>", obs);
    end
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      t   = tag_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", t, obs, exp);
      end
    end
    inv_check();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      compare_now();
    end
  endtask

  initial begin
    rst_n  = 1'b0; req_a  = 1'b1; req_b  = 1'b1;
    rst2_n = 1'b0; req_a2 = 1'b0; req_b2 = 1'b0;

    // Reset with both requests high: everything low.
    push(4'b0000, 2, "reset_hold");
    run(2);
    #1;
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // A wins the first tie, then continuous competition pre-empts every 8.
    push(4'b1100, 8, "first_a");
    push(4'b1001, 1, "gap_after_a");
    push(4'b0010, 8, "preempt_b");
    push(4'b0001, 1, "gap_after_b");
    push(4'b1100, 8, "preempt_a");
    run(26);

    // Both drop: gap then idle with sel retained at 1.
    req_a = 1'b0; req_b = 1'b0;
    push(4'b1001, 1, "drop_gap");
    push(4'b1000, 2, "idle_sel_hold");
    run(3);

    // B requests for one cycle only: minimum hold of 4.
    req_b = 1'b1;
    push(4'b0010, 1, "b_grant");
    run(1);
    req_b = 1'b0;
    push(4'b0010, 3, "b_min_hold");
    push(4'b0001, 1, "b_gap");
    push(4'b0000, 2, "b_idle");
    run(6);

    // Short A ownership so last becomes A before the reset test.
    req_a = 1'b1;
    push(4'b1100, 1, "a_grant");
    run(1);
    req_a = 1'b0;
    push(4'b1100, 3, "a_min_hold");
    push(4'b1001, 1, "a_gap");
    push(4'b1000, 1, "a_idle");
    run(5);

    // Reset in the middle of B ownership clears outputs without a clock edge.
    req_b = 1'b1;
    push(4'b0010, 2, "own_b");
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    push(4'b0000, 1, "async_rst_clear");
    compare_now();
    req_a = 1'b1;
    push(4'b0000, 1, "in_reset");
    run(1);
    #1;
    rst_n = 1'b1;
    push(4'b1100, 2, "tie_after_reset");
    run(2);
    req_a = 1'b0; req_b = 1'b0;
    push(4'b1100, 2, "post_rst_min_hold");
    push(4'b1001, 1, "post_rst_gap");
    push(4'b1000, 1, "post_rst_idle");
    run(4);

    // MAX_HOLD=0 instance: A never pre-empted, then B after A drops.
    dut_pick = 1;
    req_a2 = 1'b1; req_b2 = 1'b1;
    push(4'b1100, 100, "unlimited_a");
    run(100);
    req_a2 = 1'b0;
    push(4'b1001, 1, "unlimited_gap");
    push(4'b0010, 5, "unlimited_b");
    run(6);
    dut_pick = 0;

    // Random request traffic on the bounded instance, invariants only.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      inv_check();
      if ($urandom_range(0, 3) == 0) req_a = ~req_a;
      if ($urandom_range(0, 3) == 0) req_b = ~req_b;
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
